// File: rtl/cl_note_scheduler.sv
// Purpose: stores loader note words in BRAM, then replays them against a ms song clock as note events.
// Latency: start -> first due note valid after 3 edges; each handshake -> next note valid >= 3 edges later.
// Backpressure: note fields frozen in EMIT until note_ready; load_ready drops once a song is loaded.

module mybram #(
    parameter int LOGSIZE = 12,
    parameter int W       = 32
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [LOGSIZE-1:0] addr_i,
    input  logic [W-1:0]       din_i,
    output logic [W-1:0]       dout_o
);
    logic [W-1:0] mem_q [0:(1<<LOGSIZE)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
        dout_o <= mem_q[addr_i];
    end
endmodule

module cl_note_scheduler #(
    parameter int LOGSIZE   = 12,
    parameter int TIME_BITS = 16,
    parameter int LOOKAHEAD = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    input  logic [TIME_BITS+15:0]  load_word,
    output logic                   load_ready,
    output logic                   loaded,
    output logic                   overflow,
    input  logic                   start,
    input  logic                   ms_tick,
    output logic [TIME_BITS-1:0]   song_time,
    output logic                   note_valid,
    input  logic                   note_ready,
    output logic [5:0]             note_pitch,
    output logic [2:0]             note_string,
    output logic [3:0]             note_fret,
    output logic [TIME_BITS-1:0]   note_time,
    output logic                   done
);
    localparam int                   W         = 16 + TIME_BITS;
    localparam int                   DEPTH     = 1 << LOGSIZE;
    localparam logic [LOGSIZE:0]     LAST_SLOT = (LOGSIZE+1)'(DEPTH - 1);
    localparam logic [TIME_BITS:0]   LOOK      = (TIME_BITS+1)'(LOOKAHEAD);
    localparam logic [TIME_BITS-1:0] TIME_MAX  = '1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_EMIT
    } state_t;

    state_t               state_q;
    logic [LOGSIZE-1:0]   wr_ptr_q;
    logic [LOGSIZE-1:0]   rd_ptr_q;
    logic [LOGSIZE:0]     note_count_q;
    logic                 load_ready_q;
    logic                 loaded_q;
    logic                 overflow_q;
    logic                 done_q;
    logic                 note_valid_q;
    logic                 clk_run_q;
    logic [TIME_BITS-1:0] song_time_q;
    logic [TIME_BITS-1:0] song_time_d;
    logic [5:0]           pitch_q;
    logic [2:0]           string_q;
    logic [3:0]           fret_q;
    logic [TIME_BITS-1:0] ntime_q;

    logic [2:0]           load_sys;
    logic                 load_fire;
    logic                 load_is_note;
    logic                 load_is_end;
    logic [LOGSIZE-1:0]   ram_addr;
    logic [W-1:0]         ram_dout;
    logic [2:0]           ram_sys_unused;
    logic                 due;
    logic                 emit_fire;
    logic [LOGSIZE:0]     rd_next;

    assign load_sys     = load_word[W-1 -: 3];
    assign load_fire    = load_ready_q & load_valid;
    assign load_is_note = load_fire && (load_sys == 3'b000);
    assign load_is_end  = load_fire && (load_sys == 3'b111);

    // One port serves both phases: writes while loading, reads during playback.
    assign ram_addr = (state_q == S_LOAD) ? wr_ptr_q : rd_ptr_q;

    mybram #(
        .LOGSIZE (LOGSIZE),
        .W       (W)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (load_is_note),
        .addr_i (ram_addr),
        .din_i  (load_word),
        .dout_o (ram_dout)
    );

    // Only sys=000 words are ever written, so the stored sys field carries no information.
    assign ram_sys_unused = ram_dout[W-1 -: 3];

    // Widened by one bit so song_time + LOOKAHEAD cannot wrap past a far-future note.
    assign due       = {1'b0, ntime_q} <= ({1'b0, song_time_q} + LOOK);
    assign emit_fire = note_valid_q & note_ready;
    assign rd_next   = {1'b0, rd_ptr_q} + (LOGSIZE+1)'(1);

    always_comb begin
        song_time_d = song_time_q;
        if (clk_run_q && ms_tick && (song_time_q != TIME_MAX)) begin
            song_time_d = song_time_q + TIME_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            note_count_q <= '0;
            load_ready_q <= 1'b1;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            note_valid_q <= 1'b0;
            clk_run_q    <= 1'b0;
            song_time_q  <= '0;
            pitch_q      <= '0;
            string_q     <= '0;
            fret_q       <= '0;
            ntime_q      <= '0;
        end else begin
            song_time_q <= song_time_d;
            case (state_q)
                S_LOAD: begin
                    if (load_is_note) begin
                        wr_ptr_q     <= wr_ptr_q + LOGSIZE'(1);
                        note_count_q <= note_count_q + (LOGSIZE+1)'(1);
                        if (note_count_q == LAST_SLOT) begin
                            overflow_q   <= 1'b1;
                            loaded_q     <= 1'b1;
                            load_ready_q <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                    end else if (load_is_end) begin
                        loaded_q     <= 1'b1;
                        load_ready_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (start && loaded_q) begin
                        song_time_q <= '0;
                        rd_ptr_q    <= '0;
                        clk_run_q   <= 1'b1;
                        if (note_count_q == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            done_q  <= 1'b0;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    pitch_q  <= ram_dout[W-4 -: 6];
                    string_q <= ram_dout[W-10 -: 3];
                    fret_q   <= ram_dout[W-13 -: 4];
                    ntime_q  <= ram_dout[TIME_BITS-1:0];
                    state_q  <= S_HOLD;
                end
                S_HOLD: begin
                    if (due) begin
                        note_valid_q <= 1'b1;
                        state_q      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (emit_fire) begin
                        note_valid_q <= 1'b0;
                        rd_ptr_q     <= rd_ptr_q + LOGSIZE'(1);
                        if (rd_next == note_count_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign load_ready  = load_ready_q;
    assign loaded      = loaded_q;
    assign overflow    = overflow_q;
    assign song_time   = song_time_q;
    assign note_valid  = note_valid_q;
    assign note_pitch  = pitch_q;
    assign note_string = string_q;
    assign note_fret   = fret_q;
    assign note_time   = ntime_q;
    assign done        = done_q;
endmodule

// File: tb/tb_cl_note_scheduler.sv
// Bench for cl_note_scheduler: a LOOKAHEAD=0 and a LOOKAHEAD=2 instance share stimulus; notes checked via scoreboard.
`timescale 1ns/1ps
module tb_cl_note_scheduler;
    typedef struct packed {
        logic [5:0]  pitch;
        logic [2:0]  str;
        logic [3:0]  fret;
        logic [15:0] t;
    } note_t;

    localparam logic [31:0] END_WORD  = 32'hE000_0000;
    localparam logic [31:0] JUNK_WORD = 32'h4000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load_valid, start, ms_tick, note_ready;
    logic [31:0] load_word;
    logic        load_ready, loaded, overflow, note_valid, done;
    logic [15:0] song_time, note_time;
    logic [5:0]  note_pitch;
    logic [2:0]  note_string;
    logic [3:0]  note_fret;
    logic        la_load_ready, la_loaded, la_overflow, la_note_valid, la_done;
    logic [15:0] la_song_time, la_note_time;
    logic [5:0]  la_note_pitch;
    logic [2:0]  la_note_string;
    logic [3:0]  la_note_fret;

    cl_note_scheduler #(.LOGSIZE(2), .TIME_BITS(16), .LOOKAHEAD(0)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_word(load_word),
        .load_ready(load_ready), .loaded(loaded), .overflow(overflow), .start(start),
        .ms_tick(ms_tick), .song_time(song_time), .note_valid(note_valid), .note_ready(note_ready),
        .note_pitch(note_pitch), .note_string(note_string), .note_fret(note_fret),
        .note_time(note_time), .done(done)
    );

    cl_note_scheduler #(.LOGSIZE(2), .TIME_BITS(16), .LOOKAHEAD(2)) dut_la (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_word(load_word),
        .load_ready(la_load_ready), .loaded(la_loaded), .overflow(la_overflow), .start(start),
        .ms_tick(ms_tick), .song_time(la_song_time), .note_valid(la_note_valid), .note_ready(note_ready),
        .note_pitch(la_note_pitch), .note_string(la_note_string), .note_fret(la_note_fret),
        .note_time(la_note_time), .done(la_done)
    );

    note_t exp_q[$];
    int    emit_st[$];
    int    hs_cyc[$];
    note_t song3 [3];
    note_t mon_got, mon_exp;
    int    n_checks, n_pass, n_emit, cyc, tick_div;
    bit    sb_en, tick_en;

    function automatic logic [31:0] mk_note(input note_t n);
        return {3'b000, n};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        ms_tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tick_en && tick_div == 9) begin
                ms_tick  = 1'b1;
                tick_div = 0;
            end else begin
                ms_tick = 1'b0;
                if (tick_en) tick_div++;
            end
        end
    end

    // Scoreboard: every handshake on the LOOKAHEAD=0 instance pops one expected note.
    always @(negedge clk) begin
        if (sb_en && !reset && note_valid && note_ready) begin
            mon_got = {note_pitch, note_string, note_fret, note_time};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_extra: got note %h, required no further note", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) $display("FAIL sb_note: got %h, required %h", mon_got, mon_exp);
                else n_pass++;
            end
            n_checks++;
            if (note_time > song_time) $display("FAIL sb_due: note_time %0d emitted at song_time %0d", note_time, song_time);
            else n_pass++;
            hs_cyc.push_back(cyc);
            emit_st.push_back(int'(song_time));
            n_emit++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load_valid = 1'b0; start = 1'b0; note_ready = 1'b0; tick_en = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        load_word = w; load_valid = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        step();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (load_ready !== 1'b1) $display("FAIL rst_load_ready: got %b, required 1", load_ready); else n_pass++;
        n_checks++; if (loaded !== 1'b0) $display("FAIL rst_loaded: got %b, required 0", loaded); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b, required 0", overflow); else n_pass++;
        n_checks++; if (song_time !== 16'd0) $display("FAIL rst_song_time: got %0d, required 0", song_time); else n_pass++;
        n_checks++; if (note_valid !== 1'b0) $display("FAIL rst_note_valid: got %b, required 0", note_valid); else n_pass++;
        n_checks++;
        if ({note_pitch, note_string, note_fret, note_time} !== 29'd0)
            $display("FAIL rst_fields: got %h, required 0", {note_pitch, note_string, note_fret, note_time});
        else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b, required 0", done); else n_pass++;
        step();
    endtask

    task automatic test_load();
        song3[0] = '{pitch: 6'd10, str: 3'd1, fret: 4'd3,  t: 16'd0};
        song3[1] = '{pitch: 6'd20, str: 3'd2, fret: 4'd7,  t: 16'd5};
        song3[2] = '{pitch: 6'd33, str: 3'd5, fret: 4'd12, t: 16'd5};
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            push_word(mk_note(song3[i]));
            exp_q.push_back(song3[i]);
        end
        @(negedge clk);
        n_checks++; if (loaded !== 1'b0) $display("FAIL load_early: loaded got %b, required 0", loaded); else n_pass++;
        n_checks++; if (load_ready !== 1'b1) $display("FAIL load_ready_mid: got %b, required 1", load_ready); else n_pass++;
        push_word(END_WORD);
        load_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (loaded !== 1'b1) $display("FAIL load_loaded: got %b, required 1", loaded); else n_pass++;
        n_checks++; if (load_ready !== 1'b0) $display("FAIL load_ready_end: got %b, required 0", load_ready); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL load_overflow: got %b, required 0", overflow); else n_pass++;
        step();
    endtask

    task automatic test_playback();
        bit ok, times_ok, gap_ok;
        emit_st.delete(); hs_cyc.delete(); n_emit = 0; sb_en = 1'b1;
        note_ready = 1'b1; tick_div = 0; tick_en = 1'b1;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (note_valid !== 1'b0) $display("FAIL pb_latency: note_valid at E+%0d got 1, required 0", k); else n_pass++;
            @(posedge clk);
        end
        @(negedge clk);
        n_checks++; if (note_valid !== 1'b1) $display("FAIL pb_first_valid: got %b at E+3, required 1", note_valid); else n_pass++;
        n_checks++; if (song_time !== 16'd0) $display("FAIL pb_first_time: song_time got %0d, required 0", song_time); else n_pass++;
        step();
        wait_done(300, ok);
        n_checks++; if (!ok) $display("FAIL pb_done: done got 0 after 300 cycles, required 1"); else n_pass++;
        times_ok = (emit_st.size() == 3);
        if (times_ok) times_ok = (emit_st[0] == 0) && (emit_st[1] == 5) && (emit_st[2] == 5);
        n_checks++; if (!times_ok) $display("FAIL pb_emit_times: got %0d emits, required 3 at song_time 0,5,5", emit_st.size()); else n_pass++;
        gap_ok = (hs_cyc.size() == 3);
        if (gap_ok) gap_ok = (hs_cyc[2] - hs_cyc[1] >= 4) && (hs_cyc[1] - hs_cyc[0] >= 4);
        n_checks++; if (!gap_ok) $display("FAIL pb_gap: handshake cycles too close or missing (%0d), required >=4 apart", hs_cyc.size()); else n_pass++;
        @(negedge clk);
        n_checks++; if (note_valid !== 1'b0) $display("FAIL pb_valid_after: got %b, required 0", note_valid); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL pb_leftover: %0d notes not emitted, required 0", exp_q.size()); else n_pass++;
        step();
        tick_en = 1'b0; note_ready = 1'b0;
    endtask

    task automatic test_stall();
        bit found, stable, ok;
        note_t held;
        int st0;
        for (int i = 0; i < 3; i++) exp_q.push_back(song3[i]);
        n_emit = 0; note_ready = 1'b0; tick_div = 0; tick_en = 1'b1;
        pulse_start();
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL stall_done_clear: got %b, required 0", done); else n_pass++;
        found = note_valid;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = note_valid;
        end
        n_checks++; if (!found) $display("FAIL stall_valid: note_valid got 0 within 40 cycles, required 1"); else n_pass++;
        held = {note_pitch, note_string, note_fret, note_time};
        st0 = int'(song_time);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!note_valid || {note_pitch, note_string, note_fret, note_time} !== held) stable = 1'b0;
        end
        n_checks++; if (held !== song3[0]) $display("FAIL stall_fields: got %h, required %h", held, song3[0]); else n_pass++;
        n_checks++; if (!stable) $display("FAIL stall_hold: valid/fields changed while stalled, required stable"); else n_pass++;
        n_checks++; if (int'(song_time) != st0 + 2) $display("FAIL stall_clock: song_time got %0d, required %0d", song_time, st0 + 2); else n_pass++;
        step();
        note_ready = 1'b1;
        wait_done(300, ok);
        n_checks++; if (!ok || n_emit != 3) $display("FAIL stall_replay: done %b emits %0d, required 1 and 3", ok, n_emit); else n_pass++;
        tick_en = 1'b0; note_ready = 1'b0;
    endtask

    task automatic test_overflow();
        note_t n;
        bit ok;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            n = '{pitch: 6'(i + 1), str: 3'(i), fret: 4'(i + 2), t: 16'(i)};
            if (i == 2) push_word(JUNK_WORD);
            push_word(mk_note(n));
            exp_q.push_back(n);
            if (i < 3) begin
                @(negedge clk);
                n_checks++; if (loaded !== 1'b0) $display("FAIL ovf_early: loaded got 1 after note %0d, required 0", i); else n_pass++;
            end
        end
        @(negedge clk);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b, required 1", overflow); else n_pass++;
        n_checks++; if (loaded !== 1'b1) $display("FAIL ovf_loaded: got %b, required 1", loaded); else n_pass++;
        n_checks++; if (load_ready !== 1'b0) $display("FAIL ovf_ready: got %b, required 0", load_ready); else n_pass++;
        n = '{pitch: 6'd63, str: 3'd7, fret: 4'd15, t: 16'd0};
        push_word(mk_note(n));
        load_valid = 1'b0;
        n_emit = 0; note_ready = 1'b1; tick_div = 0; tick_en = 1'b1;
        pulse_start();
        wait_done(300, ok);
        n_checks++; if (!ok) $display("FAIL ovf_done: done got 0, required 1"); else n_pass++;
        n_checks++; if (n_emit != 4) $display("FAIL ovf_count: got %0d emits, required 4", n_emit); else n_pass++;
        tick_en = 1'b0; note_ready = 1'b0;
    endtask

    task automatic test_lookahead();
        note_t n;
        bit la_seen, main_seen;
        int la_st, main_st, la_t;
        do_reset();
        exp_q.delete();
        n = '{pitch: 6'd7, str: 3'd3, fret: 4'd9, t: 16'd5};
        push_word(mk_note(n));
        push_word(END_WORD);
        load_valid = 1'b0;
        exp_q.push_back(n);
        n_emit = 0; note_ready = 1'b1; tick_div = 0; tick_en = 1'b1;
        pulse_start();
        la_seen = 1'b0; main_seen = 1'b0; la_st = -1; main_st = -1; la_t = -1;
        for (int i = 0; i < 300 && !(la_seen && main_seen); i++) begin
            @(negedge clk);
            if (!la_seen && la_note_valid) begin la_seen = 1'b1; la_st = int'(la_song_time); la_t = int'(la_note_time); end
            if (!main_seen && note_valid) begin main_seen = 1'b1; main_st = int'(song_time); end
        end
        n_checks++; if (la_st != 3) $display("FAIL la_rise: song_time got %0d, required 3", la_st); else n_pass++;
        n_checks++; if (la_t != 5) $display("FAIL la_note_time: got %0d, required 5", la_t); else n_pass++;
        n_checks++; if (main_st != 5) $display("FAIL la0_rise: song_time got %0d, required 5", main_st); else n_pass++;
        step(); step();
        tick_en = 1'b0; note_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        note_t n0, n1;
        bit bad;
        do_reset();
        exp_q.delete();
        n0 = '{pitch: 6'd45, str: 3'd6, fret: 4'd11, t: 16'd50};
        n1 = '{pitch: 6'd46, str: 3'd6, fret: 4'd11, t: 16'd60};
        push_word(mk_note(n0));
        push_word(mk_note(n1));
        push_word(END_WORD);
        load_valid = 1'b0;
        note_ready = 1'b1;
        pulse_start();
        step(); step();
        @(negedge clk);
        n_checks++; if (note_valid !== 1'b0) $display("FAIL mid_hold_valid: got %b, required 0", note_valid); else n_pass++;
        n_checks++; if (note_pitch !== 6'd45) $display("FAIL mid_hold_pitch: got %0d, required 45", note_pitch); else n_pass++;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (loaded !== 1'b0) $display("FAIL mid_loaded: got %b, required 0", loaded); else n_pass++;
        n_checks++; if (load_ready !== 1'b1) $display("FAIL mid_load_ready: got %b, required 1", load_ready); else n_pass++;
        n_checks++; if (note_pitch !== 6'd0 || note_time !== 16'd0) $display("FAIL mid_fields: pitch %0d time %0d, required 0", note_pitch, note_time); else n_pass++;
        step();
        pulse_start();
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (note_valid || !load_ready || done || loaded) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL mid_start_ignored: playback reacted to start without a song, required no effect"); else n_pass++;
        step();
        note_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_word = '0; start = 1'b0; note_ready = 1'b0;
        tick_en = 1'b0; tick_div = 0; sb_en = 1'b0; n_checks = 0; n_pass = 0; n_emit = 0;
        test_reset();
        test_load();
        test_playback();
        test_stall();
        test_overflow();
        test_lookahead();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
